// File: rtl/rst_seq_pkg.sv
// Shared types for the reset sequencer: state encodings visible on state_dbg
// and a small elaboration-time helper used for counter sizing.
package rst_seq_pkg;

    localparam int STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        ST_RESET   = 3'd0,
        ST_HOLD    = 3'd1,
        ST_INIT    = 3'd2,
        ST_RELEASE = 3'd3,
        ST_RUN     = 3'd4,
        ST_FAULT   = 3'd5
    } state_t;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/rst_seq_ctrl_if.sv
// Handshake/status bundle between the reset sequencer (master) and the
// CRC engine plus downstream reset consumers (slave).
interface rst_seq_ctrl_if
    import rst_seq_pkg::*;
#(
    parameter int N_STAGES = 3
);
    logic                soft_rst_req;
    logic                init_done;
    logic                init_req;
    logic [N_STAGES-1:0] rst_n_out;
    logic                ready;
    logic                fault;
    logic [STATE_W-1:0]  state_dbg;

    modport master (
        input  soft_rst_req,
        input  init_done,
        output init_req,
        output rst_n_out,
        output ready,
        output fault,
        output state_dbg
    );

    modport slave (
        output soft_rst_req,
        output init_done,
        input  init_req,
        input  rst_n_out,
        input  ready,
        input  fault,
        input  state_dbg
    );
endinterface

// File: rtl/rst_seq_sync.sv
// Two-flop synchronizer for the active-low asynchronous reset: assertion is
// immediate, release reaches rst_int two clock edges later.
module rst_seq_sync (
    input  logic clk,
    input  logic rst_async,
    output logic rst_int
);
    logic meta_reg;
    logic sync_reg;

    always_ff @(posedge clk or negedge rst_async) begin
        if (!rst_async) begin
            meta_reg <= 1'b0;
            sync_reg <= 1'b0;
        end else begin
            meta_reg <= 1'b1;
            sync_reg <= meta_reg;
        end
    end

    assign rst_int = sync_reg;
endmodule

// File: rtl/rst_seq_ctrl.sv
// Reset sequencer: hold-off, CRC init handshake, staggered downstream release, ready.
// Optional INIT watchdog and FAULT state are built only when RST_SEQ_TIMEOUT_EN is defined.
module rst_seq_ctrl
    import rst_seq_pkg::*;
#(
    parameter int HOLD_CYCLES    = 16,
    parameter int N_STAGES       = 3,
    parameter int STAGE_GAP      = 4,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic           clk,
    input  logic           rst_async,
    rst_seq_ctrl_if.master bus
);

`ifdef RST_SEQ_TIMEOUT_EN
    localparam int CNT_SPAN = max_int(max_int(HOLD_CYCLES, N_STAGES * STAGE_GAP), TIMEOUT_CYCLES);
`else
    localparam int CNT_SPAN = max_int(HOLD_CYCLES, N_STAGES * STAGE_GAP);
`endif
    localparam int CNT_W = $clog2(CNT_SPAN) + 1;

    localparam logic [CNT_W-1:0] CNT_MAX    = '1;
    localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] READY_LAST = CNT_W'(N_STAGES * STAGE_GAP - 1);

    if (HOLD_CYCLES < 1 || N_STAGES < 1 || N_STAGES > 8 || STAGE_GAP < 1 ||
        TIMEOUT_CYCLES < 2) begin : g_param_err
        $error("rst_seq_ctrl: parameter out of range");
    end

    logic                rst_int;
    state_t              state_reg,    state_next;
    logic [CNT_W-1:0]    cnt_reg,      cnt_next;
    logic                init_req_reg, init_req_next;
    logic [N_STAGES-1:0] rst_n_reg,    rst_n_next;
    logic                ready_reg,    ready_next;
    logic                soft_hit;
    logic                cnt_clr;
    logic [N_STAGES-1:0] stage_hit;

`ifdef RST_SEQ_TIMEOUT_EN
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    logic fault_reg, fault_next;
`endif

    rst_seq_sync u_sync (
        .clk       (clk),
        .rst_async (rst_async),
        .rst_int   (rst_int)
    );

    // The counter restarts on RELEASE entry, so stage k is due when it reads k*STAGE_GAP-1.
    for (genvar gi = 0; gi < N_STAGES; gi++) begin : g_stage
        if (gi == 0) begin : g_first
            assign stage_hit[gi] = 1'b0;
        end else begin : g_rest
            localparam logic [CNT_W-1:0] HIT_AT = CNT_W'(gi * STAGE_GAP - 1);
            assign stage_hit[gi] = (cnt_reg == HIT_AT);
        end
    end

    always_comb begin
        state_next = state_reg;
        rst_n_next = rst_n_reg;
        ready_next = ready_reg;
`ifdef RST_SEQ_TIMEOUT_EN
        fault_next = fault_reg;
`endif
        case (state_reg)
            ST_RESET: begin
                if (rst_int) state_next = ST_HOLD;
            end
            ST_HOLD: begin
                if (cnt_reg == HOLD_LAST) state_next = ST_INIT;
            end
            ST_INIT: begin
                if (bus.init_done) begin
                    state_next = ST_RELEASE;
                    rst_n_next = N_STAGES'(1);
                end
`ifdef RST_SEQ_TIMEOUT_EN
                else if (cnt_reg == TIMEOUT_LAST) begin
                    state_next = ST_FAULT;
                    fault_next = 1'b1;
                end
`endif
            end
            ST_RELEASE: begin
                rst_n_next = rst_n_reg | stage_hit;
                if (cnt_reg == READY_LAST) begin
                    ready_next = 1'b1;
                    state_next = ST_RUN;
                end
            end
            ST_RUN: begin
            end
`ifdef RST_SEQ_TIMEOUT_EN
            ST_FAULT: begin
            end
`endif
            default: begin
                // Undecoded encodings fall back to RESET behaviour.
                state_next = rst_int ? ST_HOLD : ST_RESET;
                rst_n_next = '0;
                ready_next = 1'b0;
            end
        endcase

        // Soft reset overrides any transition taken above, including init_done.
        soft_hit = bus.soft_rst_req && (state_reg != ST_RESET);
        if (soft_hit) begin
            state_next = ST_HOLD;
            rst_n_next = '0;
            ready_next = 1'b0;
`ifdef RST_SEQ_TIMEOUT_EN
            fault_next = 1'b0;
`endif
        end

        cnt_clr       = soft_hit || (state_next != state_reg);
        init_req_next = (state_next == ST_INIT);

        if (cnt_clr) begin
            cnt_next = '0;
        end else if (cnt_reg != CNT_MAX) begin
            cnt_next = cnt_reg + 1'b1;
        end else begin
            cnt_next = cnt_reg;
        end
    end

    always_ff @(posedge clk or negedge rst_async) begin
        if (!rst_async) begin
            state_reg    <= ST_RESET;
            cnt_reg      <= '0;
            init_req_reg <= 1'b0;
            rst_n_reg    <= '0;
            ready_reg    <= 1'b0;
        end else begin
            state_reg    <= state_next;
            cnt_reg      <= cnt_next;
            init_req_reg <= init_req_next;
            rst_n_reg    <= rst_n_next;
            ready_reg    <= ready_next;
        end
    end

`ifdef RST_SEQ_TIMEOUT_EN
    always_ff @(posedge clk or negedge rst_async) begin
        if (!rst_async) begin
            fault_reg <= 1'b0;
        end else begin
            fault_reg <= fault_next;
        end
    end
    assign bus.fault = fault_reg;
`else
    assign bus.fault = 1'b0;
`endif

    assign bus.init_req  = init_req_reg;
    assign bus.rst_n_out = rst_n_reg;
    assign bus.ready     = ready_reg;
    assign bus.state_dbg = state_reg;

endmodule

// File: tb/tb_rst_seq_ctrl.sv
// Scoreboard bench for rst_seq_ctrl: stimulus queues every expected output change
// (edge number + output snapshot); a negedge monitor pops and compares on each change.
`timescale 1ns/1ps
module tb_rst_seq_ctrl;
    import rst_seq_pkg::*;

    typedef struct {
        int         edge_n;
        logic [8:0] snap;
    } exp_t;

    logic clk = 1'b0;
    logic rst_async;
    int   cyc      = 0;
    int   base     = 0;
    int   chk_cnt  = 0;
    int   pass_cnt = 0;
    bit   mon_en   = 1'b0;
    exp_t exp_q[$];
    exp_t mon_ex;
    logic [8:0] prev_snap;
    logic [8:0] cur_snap;

    rst_seq_ctrl_if #(.N_STAGES(3)) bus_if ();

    rst_seq_ctrl #(
        .HOLD_CYCLES    (16),
        .N_STAGES       (3),
        .STAGE_GAP      (4),
        .TIMEOUT_CYCLES (256)
    ) dut (
        .clk       (clk),
        .rst_async (rst_async),
        .bus       (bus_if.master)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    assign cur_snap = {bus_if.state_dbg, bus_if.init_req, bus_if.rst_n_out,
                       bus_if.ready, bus_if.fault};

    function automatic logic [8:0] mk(input logic [2:0] st, input logic ir,
                                      input logic [2:0] rn, input logic rdy,
                                      input logic flt);
        return {st, ir, rn, rdy, flt};
    endfunction

    task automatic expect_at(input int e, input logic [8:0] s);
        exp_q.push_back('{e, s});
    endtask

    task automatic check(input string name, input logic [8:0] got, input logic [8:0] req);
        chk_cnt++;
        if (got === req) pass_cnt++;
        else $display("FAIL %s: got %b, required %b", name, got, req);
    endtask

    // Returns at the negedge following edge n of the current bring-up.
    task automatic wait_after(input int n);
        while ((cyc - base) < n) @(negedge clk);
    endtask

    task automatic pulse_init_done(input int e);
        wait_after(e - 1);
        bus_if.init_done = 1'b1;
        wait_after(e);
        bus_if.init_done = 1'b0;
    endtask

    task automatic pulse_soft(input int e);
        wait_after(e - 1);
        bus_if.soft_rst_req = 1'b1;
        wait_after(e);
        bus_if.soft_rst_req = 1'b0;
    endtask

    task automatic exp_release(input int e);
        expect_at(e,      mk(ST_RELEASE, 1'b0, 3'b001, 1'b0, 1'b0));
        expect_at(e + 4,  mk(ST_RELEASE, 1'b0, 3'b011, 1'b0, 1'b0));
        expect_at(e + 8,  mk(ST_RELEASE, 1'b0, 3'b111, 1'b0, 1'b0));
        expect_at(e + 12, mk(ST_RUN,     1'b0, 3'b111, 1'b1, 1'b0));
    endtask

    // Release rst_async between edges; the next rising edge is edge 0.
    task automatic bringup();
        expect_at(2,  mk(ST_HOLD, 1'b0, 3'b000, 1'b0, 1'b0));
        expect_at(18, mk(ST_INIT, 1'b1, 3'b000, 1'b0, 1'b0));
        @(negedge clk);
        rst_async = 1'b1;
        base      = cyc + 1;
    endtask

    always @(negedge clk) begin
        if (mon_en && (cur_snap !== prev_snap)) begin
            chk_cnt++;
            if (exp_q.size() == 0) begin
                $display("FAIL event: unexpected change at edge %0d to %b", cyc - base, cur_snap);
            end else begin
                mon_ex = exp_q.pop_front();
                if ((mon_ex.edge_n == cyc - base) && (mon_ex.snap === cur_snap)) begin
                    pass_cnt++;
                    $display("event edge %0d snap %b ok", cyc - base, cur_snap);
                end else begin
                    $display("FAIL event: got edge %0d snap %b, required edge %0d snap %b",
                             cyc - base, cur_snap, mon_ex.edge_n, mon_ex.snap);
                end
            end
            prev_snap = cur_snap;
        end
    end

    initial begin
        rst_async           = 1'b1;
        bus_if.soft_rst_req = 1'b0;
        bus_if.init_done    = 1'b0;
        #1 rst_async = 1'b0;
        repeat (5) @(negedge clk);
        check("reset_state", cur_snap, mk(ST_RESET, 1'b0, 3'b000, 1'b0, 1'b0));
        prev_snap = cur_snap;
        mon_en    = 1'b1;

        // Power-up, then a one-cycle soft reset in RUN, then async reset mid-RELEASE.
        bringup();
        exp_release(21);
        expect_at(40, mk(ST_HOLD,    1'b0, 3'b000, 1'b0, 1'b0));
        expect_at(56, mk(ST_INIT,    1'b1, 3'b000, 1'b0, 1'b0));
        expect_at(59, mk(ST_RELEASE, 1'b0, 3'b001, 1'b0, 1'b0));
        expect_at(63, mk(ST_RELEASE, 1'b0, 3'b011, 1'b0, 1'b0));
        expect_at(64, mk(ST_RESET,   1'b0, 3'b000, 1'b0, 1'b0));
        pulse_init_done(21);
        pulse_soft(40);
        pulse_init_done(59);
        wait_after(63);
        @(posedge clk);
        #2 rst_async = 1'b0;
        #1 check("async_clear", cur_snap, mk(ST_RESET, 1'b0, 3'b000, 1'b0, 1'b0));
        repeat (5) @(negedge clk);

        // Second bring-up: same timing, stray init_done in HOLD, collision, long INIT.
        bringup();
        exp_release(21);
        expect_at(35, mk(ST_HOLD, 1'b0, 3'b000, 1'b0, 1'b0));
        expect_at(51, mk(ST_INIT, 1'b1, 3'b000, 1'b0, 1'b0));
        expect_at(53, mk(ST_HOLD, 1'b0, 3'b000, 1'b0, 1'b0));
        expect_at(71, mk(ST_INIT, 1'b1, 3'b000, 1'b0, 1'b0));
`ifdef RST_SEQ_TIMEOUT_EN
        expect_at(327, mk(ST_FAULT, 1'b0, 3'b000, 1'b0, 1'b1));
        expect_at(330, mk(ST_HOLD,  1'b0, 3'b000, 1'b0, 1'b0));
        expect_at(346, mk(ST_INIT,  1'b1, 3'b000, 1'b0, 1'b0));
        exp_release(349);
`else
        exp_release(1071);
`endif
        pulse_init_done(10);
        pulse_init_done(21);
        pulse_soft(35);
        // soft_rst_req sampled at edges 53..55, init_done also at 53.
        wait_after(52);
        bus_if.soft_rst_req = 1'b1;
        bus_if.init_done    = 1'b1;
        wait_after(53);
        bus_if.init_done    = 1'b0;
        wait_after(55);
        bus_if.soft_rst_req = 1'b0;
`ifdef RST_SEQ_TIMEOUT_EN
        wait_after(327);
        check("fault_state", cur_snap, mk(ST_FAULT, 1'b0, 3'b000, 1'b0, 1'b1));
        pulse_soft(330);
        pulse_init_done(349);
        wait_after(375);
`else
        wait_after(1070);
        check("init_wait", cur_snap, mk(ST_INIT, 1'b1, 3'b000, 1'b0, 1'b0));
        pulse_init_done(1071);
        wait_after(1095);
`endif

        while (exp_q.size() > 0) begin
            mon_ex = exp_q.pop_front();
            chk_cnt++;
            $display("FAIL missing_event: got nothing, required edge %0d snap %b",
                     mon_ex.edge_n, mon_ex.snap);
        end
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end
endmodule

// File: doc/rst_seq_ctrl.md
# rst_seq_ctrl

Reset sequencer that sits directly downstream of the 2-flop reset synchronizer in the CRC subsystem. It turns a synchronized reset release into an ordered bring-up:
- hold-off period;
- CRC engine init handshake;
- staggered release of `N_STAGES` downstream active-low resets;
- final `ready` indication.

A synchronous soft-reset request re-runs the sequence without asserting the asynchronous reset.

## Interface
- `HOLD_CYCLES`, 16: cycles spent in HOLD after synchronized release (≥1).
- `N_STAGES`, 3: number of downstream reset outputs (1..8).
- `STAGE_GAP`, 4: cycles between successive stage releases, and from last release to `ready` (≥1).
- `TIMEOUT_CYCLES`, 256: INIT watchdog limit (≥2); used only with `RST_SEQ_TIMEOUT_EN`.
- `clk` in 1: clock.
- `rst_async` in 1: reset, asynchronous, active-low. Synchronized internally; its assertion clears every flop immediately.
- `soft_rst_req` in 1: synchronous level/pulse request to restart the sequence.
- `init_req` out 1: level request to the CRC engine to initialise.
- `init_done` in 1: CRC engine init complete, sampled only in INIT.
- `rst_n_out` out `N_STAGES`: downstream active-low resets; bit 0 is released first.
- `ready` out 1: sequence complete.
- `fault` out 1: INIT watchdog expired.
- `state_dbg` out 3: current state encoding.

## Operation
- Internal 2-flop synchronizer on `rst_async` produces `rst_int`. All flops are async-cleared by `rst_async` low.
- Reset values: `init_req`=0, `rst_n_out`=0, `ready`=0, `fault`=0, `state_dbg`=RESET.
- States: RESET, HOLD, INIT, RELEASE, RUN, FAULT.
- State transitions:
  - RESET→HOLD on the first edge with `rst_int`=1.
  - HOLD→INIT after exactly `HOLD_CYCLES` cycles in HOLD.
  - INIT→RELEASE on an edge sampling `init_done`=1.
  - RELEASE→RUN when `ready` sets.
- RELEASE sequencing: `rst_n_out[0]` sets on RELEASE entry. Bit k sets `k*STAGE_GAP` cycles after entry. `ready` sets `N_STAGES*STAGE_GAP` cycles after entry.
- Released bits stay 1 until restart or reset; `rst_n_out` is monotonic within one sequence.
- `init_req` = 1 exactly while in INIT (registered). It deasserts on the same edge RELEASE is entered.
- Single shared counter, width `$clog2(max(HOLD_CYCLES, N_STAGES*STAGE_GAP, TIMEOUT_CYCLES))+1`. It clears on every state entry and saturates at its maximum.
- `soft_rst_req`=1 at an edge in any state other than RESET:
  - goes to HOLD;
  - clears `rst_n_out`, `ready`, `init_req`, `fault` on that edge.
- Simultaneous `soft_rst_req` and `init_done`: soft reset wins.
- `soft_rst_req` held high keeps the block in HOLD with the counter cleared.
- `init_done` outside INIT is ignored.
- FAULT: `fault`=1, `rst_n_out`=0, `init_req`=0, `ready`=0. Exit only via `soft_rst_req` or `rst_async`.

## Timing
- Edge 0 is the first rising edge with `rst_async` high.
  - `rst_int`=1 after edge 1.
  - HOLD is entered at edge 2.
  - INIT is entered (and `init_req` rises) at edge `2+HOLD_CYCLES`.
- `init_done` sampled high at edge E:
  - `rst_n_out[k]` rises at edge `E+k*STAGE_GAP`;
  - `ready` rises at edge `E+N_STAGES*STAGE_GAP`.
- Watchdog: `fault` rises at edge `Einit+TIMEOUT_CYCLES`, where Einit is the INIT entry edge, if no `init_done` is seen.
- Assertion of `rst_async` clears outputs asynchronously, with no clock required, including mid-RELEASE.
- Soft reset takes effect on the next edge (latency 1).

## Configuration
- `RST_SEQ_TIMEOUT_EN` defined: INIT watchdog is active and FAULT is reachable as above.
- `RST_SEQ_TIMEOUT_EN` undefined:
  - INIT waits indefinitely;
  - `fault` is tied 0;
  - FAULT encoding is unused (decoding to RESET behaviour if ever reached);
  - `TIMEOUT_CYCLES` is ignored in counter sizing.

## Structure
- Package `rst_seq_pkg` holds:
  - state typedef and encodings: RESET=0, HOLD=1, INIT=2, RELEASE=3, RUN=4, FAULT=5;
  - the `state_dbg` width constant.
- Sub-module `rst_seq_sync`: 2-flop active-low reset synchronizer producing `rst_int`.
- FSM, counter and output registers live in the top level.

## Test plan
All scenarios use default parameters.
- Power-up: `rst_async` low 5 cycles, then released at edge 0; `init_done` pulses at edge 21.
  - `init_req` is 1 over edges 18..20 and falls at 21.
  - `rst_n_out` = 001@21, 011@25, 111@29; `ready`@33.
- Timeout (macro on): `init_done` held 0 → `fault`=1 at edge 274, `init_req`=0, `rst_n_out`=000. Then a `soft_rst_req` pulse → `fault`=0 next edge and `init_req` re-rises 16 cycles later.
- Soft reset in RUN: one-cycle `soft_rst_req` → next edge `rst_n_out`=000, `ready`=0; INIT re-entered 16 cycles after that edge.
- Async reset mid-RELEASE: drop `rst_async` while `rst_n_out`=011, between clock edges → outputs go to 000 without a clock edge; after release the full sequence repeats with the same timing as scenario 1.
- Collision: `soft_rst_req` and `init_done` both 1 at the same INIT edge → state HOLD, `rst_n_out` stays 000, `init_req`=0.
- Macro off: `init_done` withheld 1000 cycles → remains in INIT, `fault`=0; late `init_done` → normal release.
